// File: rtl/rec_gen_pkg.sv
// Shared types and constants for the rectangular-wave NCO.
// Holds the run/idle state encoding, default parameter values and the
// amplitude saturation helper used when a new amplitude is accepted.
package rec_gen_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_OUT_W   = 8;
   localparam int DEF_PHASE_W = 16;
   localparam int DEF_DUTY_W  = 8;
   localparam int DEF_AMP     = 40;

   // Clamp an unsigned magnitude so that both +mag and -mag fit in a
   // w-bit two's complement sample (largest legal value 2^(w-1)-1).
   function automatic logic [31:0] sat_amp(input logic [31:0] mag, input int w);
      logic [31:0] lim;
      lim = (32'd1 << (w - 1)) - 32'd1;
      return (mag > lim) ? lim : mag;
   endfunction

endpackage

// File: rtl/rec_phase_acc.sv
// Phase accumulator for the rectangular-wave NCO.
// Adds the active tuning word every running cycle, flags the carry out as a
// wrap, and clears the phase while idle. With REC_GEN_SYNC_EN defined a sync
// input forces the phase back to zero and is reported as a wrap.
module rec_phase_acc #(
   parameter int PHASE_W = 16,
   parameter int DUTY_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
`ifdef REC_GEN_SYNC_EN
   input  logic              sync,
`endif
   input  logic [PHASE_W-1:0] ftw,
   output logic [DUTY_W-1:0]  phase_top,
   output logic               wrap
);

   logic [PHASE_W-1:0] phase_p0;
   logic [PHASE_W:0]   sum_p0;
   logic               sync_hit;

   // Next phase and carry; a sync request behaves exactly like a carry.
   always_comb begin
      sum_p0 = {1'b0, phase_p0} + {1'b0, ftw};
`ifdef REC_GEN_SYNC_EN
      sync_hit = run & sync;
`else
      sync_hit = 1'b0;
`endif
      wrap = run & (sum_p0[PHASE_W] | sync_hit);
   end

   // Phase register: zero while idle or on sync, otherwise modulo add.
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         phase_p0 <= '0;
      end else if (sync_hit) begin
         phase_p0 <= '0;
      end else begin
         phase_p0 <= sum_p0[PHASE_W-1:0];
      end
   end

   assign phase_top = phase_p0[PHASE_W-1 -: DUTY_W];

endmodule

// File: rtl/rec_gen_nco.sv
// Rectangular-wave NCO: phase accumulator compared against a duty threshold
// produces a +amp / -amp sample stream with a one-cycle registered latency.
// New configuration is accepted into a single pending slot and only becomes
// active at a period boundary (or immediately while idle), so a period is
// never altered part-way through.
// Optional macro REC_GEN_SYNC_EN adds a sync input that restarts the period.
module rec_gen_nco
   import rec_gen_pkg::*;
#(
   parameter int OUT_W   = DEF_OUT_W,
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int DUTY_W  = DEF_DUTY_W,
   parameter int AMP_DEF = DEF_AMP
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
`ifdef REC_GEN_SYNC_EN
   input  logic                     sync,
`endif
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [PHASE_W-1:0]       cfg_ftw,
   input  logic [DUTY_W-1:0]        cfg_duty,
   input  logic [OUT_W-1:0]         cfg_amp,
   output logic signed [OUT_W-1:0]  wave_out,
   output logic                     level,
   output logic                     period_start
);

   localparam logic [OUT_W-1:0]  AMP_RST  = OUT_W'(sat_amp(32'(AMP_DEF), OUT_W));
   localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(1 << (DUTY_W - 1));

   state_t state, state_nx;
   logic   run;

   logic                pend_full;
   logic [PHASE_W-1:0]  pend_ftw;
   logic [DUTY_W-1:0]   pend_duty;
   logic [OUT_W-1:0]    pend_amp;
   logic [PHASE_W-1:0]  ftw_act;
   logic [DUTY_W-1:0]   duty_act;
   logic [OUT_W-1:0]    amp_act;
   logic                take;
   logic                apply;

   logic [DUTY_W-1:0]   phase_top;
   logic                wrap;
   logic                hi_p0;
   logic signed [OUT_W-1:0] amp_pos;
   logic signed [OUT_W-1:0] amp_neg;

   logic signed [OUT_W-1:0] wave_p1;
   logic                level_p1;
   logic                pstart_p1;
   logic                entry_p0;
   logic                wrap_p0;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state: follow en on every edge.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (en)  state_nx = ST_RUN;
         ST_RUN:  if (!en) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   assign run = (state == ST_RUN);

   rec_phase_acc #(
      .PHASE_W (PHASE_W),
      .DUTY_W  (DUTY_W)
   ) u_acc (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
`ifdef REC_GEN_SYNC_EN
      .sync      (sync),
`endif
      .ftw       (ftw_act),
      .phase_top (phase_top),
      .wrap      (wrap)
   );

   // A full slot blocks new offers, so take and apply never coincide.
   assign cfg_ready = !pend_full;
   assign take      = cfg_valid & !pend_full;
   assign apply     = pend_full & (!run | wrap);

   // Pending-slot occupancy and the active configuration set.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_full <= 1'b0;
         ftw_act   <= '0;
         duty_act  <= DUTY_RST;
         amp_act   <= AMP_RST;
      end else if (take) begin
         pend_full <= 1'b1;
      end else if (apply) begin
         pend_full <= 1'b0;
         ftw_act   <= pend_ftw;
         duty_act  <= pend_duty;
         amp_act   <= pend_amp;
      end
   end

   // Pending payload; amplitude is clamped on capture.
   always_ff @(posedge clk) begin
      if (take) begin
         pend_ftw  <= cfg_ftw;
         pend_duty <= cfg_duty;
         pend_amp  <= OUT_W'(sat_amp(32'(cfg_amp), OUT_W));
      end
   end

   // ---- stage p0: threshold compare on the pre-update phase ----
   assign hi_p0   = (phase_top < duty_act);
   assign amp_pos = $signed(amp_act);
   assign amp_neg = -amp_pos;

   // ---- stage p1: registered sample, level and period marker ----
   // entry_p0 marks the first running cycle after idle; wrap_p0 the cycle
   // after a wrap. A frozen accumulator (ftw 0) never reports a period start.
   always_ff @(posedge clk) begin
      if (rst) begin
         wave_p1   <= '0;
         level_p1  <= 1'b0;
         pstart_p1 <= 1'b0;
         entry_p0  <= 1'b0;
         wrap_p0   <= 1'b0;
      end else if (!run) begin
         wave_p1   <= '0;
         level_p1  <= 1'b0;
         pstart_p1 <= 1'b0;
         entry_p0  <= 1'b1;
         wrap_p0   <= 1'b0;
      end else begin
         wave_p1   <= hi_p0 ? amp_pos : amp_neg;
         level_p1  <= hi_p0;
         pstart_p1 <= (entry_p0 & (ftw_act != '0)) | wrap_p0;
         entry_p0  <= 1'b0;
         wrap_p0   <= wrap;
      end
   end

   assign wave_out     = wave_p1;
   assign level        = level_p1;
   assign period_start = pstart_p1;

endmodule

// File: tb/tb_rec_gen_nco.sv
// Testbench for rec_gen_nco (default parameters). Builds with or without
// REC_GEN_SYNC_EN; the sync sequence is only exercised when it is defined.
`timescale 1ns/1ps
module tb_rec_gen_nco;

   localparam int OUT_W   = 8;
   localparam int PHASE_W = 16;
   localparam int DUTY_W  = 8;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    en;
`ifdef REC_GEN_SYNC_EN
   logic                    sync;
`endif
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [PHASE_W-1:0]      cfg_ftw;
   logic [DUTY_W-1:0]       cfg_duty;
   logic [OUT_W-1:0]        cfg_amp;
   logic signed [OUT_W-1:0] wave_out;
   logic                    level;
   logic                    period_start;

   always #5 clk = ~clk;

   rec_gen_nco #(
      .OUT_W   (OUT_W),
      .PHASE_W (PHASE_W),
      .DUTY_W  (DUTY_W),
      .AMP_DEF (40)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
`ifdef REC_GEN_SYNC_EN
      .sync         (sync),
`endif
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_ftw      (cfg_ftw),
      .cfg_duty     (cfg_duty),
      .cfg_amp      (cfg_amp),
      .wave_out     (wave_out),
      .level        (level),
      .period_start (period_start)
   );

   typedef struct {
      int wave;
      bit lvl;
      bit ps;
   } samp_t;

   typedef struct {
      logic [15:0] ftw;
      logic [7:0]  duty;
      logic [7:0]  amp;
      int          hi_n;
      int          lo_n;
      int          amp_exp;
      bit          ps;
   } vec_t;

   samp_t sb[$];
   vec_t  vt[7];
   int    n_chk  = 0;
   int    n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_period(input int hi_n, input int lo_n, input int amp, input bit ps);
      for (int i = 0; i < hi_n + lo_n; i++) begin
         samp_t s;
         s.wave = (i < hi_n) ? amp : -amp;
         s.lvl  = (i < hi_n);
         s.ps   = ps && (i == 0);
         sb.push_back(s);
      end
   endtask

   task automatic check_sample(input string name);
      samp_t s;
      tick;
      if (sb.size() == 0) begin
         n_chk++;
         $display("FAIL %s: scoreboard empty, got wave %0d", name, wave_out);
      end else begin
         s = sb.pop_front();
         check({name, " wave"},   int'(wave_out),     s.wave);
         check({name, " level"},  int'(level),        int'(s.lvl));
         check({name, " pstart"}, int'(period_start), int'(s.ps));
      end
   endtask

   // Load a config while idle, then enable; leaves the bench just before sample 0.
   task automatic start_cfg(input logic [15:0] ftw, input logic [7:0] duty, input logic [7:0] amp);
      en        = 1'b0;
      cfg_valid = 1'b1;
      cfg_ftw   = ftw;
      cfg_duty  = duty;
      cfg_amp   = amp;
      tick;
      cfg_valid = 1'b0;
      check("ready after capture", int'(cfg_ready), 0);
      tick;
      check("ready after idle apply", int'(cfg_ready), 1);
      en = 1'b1;
      tick;
      check("wave on run entry edge", int'(wave_out), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      vt[0] = '{16'h1000, 8'h80, 8'd40,  8,   8,  40,  1'b1};
      vt[1] = '{16'h1000, 8'h40, 8'd40,  4,   12, 40,  1'b1};
      vt[2] = '{16'h1000, 8'h80, 8'hFF,  8,   8,  127, 1'b1};
      vt[3] = '{16'h1000, 8'h00, 8'd40,  0,   16, 40,  1'b1};
      vt[4] = '{16'h0100, 8'hFF, 8'd40,  255, 1,  40,  1'b1};
      vt[5] = '{16'h2000, 8'h80, 8'd100, 4,   4,  100, 1'b1};
      vt[6] = '{16'h0000, 8'h80, 8'd40,  16,  0,  40,  1'b0};

      rst       = 1'b1;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_ftw   = '0;
      cfg_duty  = '0;
      cfg_amp   = '0;
`ifdef REC_GEN_SYNC_EN
      sync      = 1'b0;
`endif
      tick;
      tick;
      check("reset wave",      int'(wave_out),     0);
      check("reset level",     int'(level),        0);
      check("reset pstart",    int'(period_start), 0);
      check("reset cfg_ready", int'(cfg_ready),    1);
      rst = 1'b0;

      // Table-driven periods: two full periods per configuration.
      for (int r = 0; r < 7; r++) begin
         start_cfg(vt[r].ftw, vt[r].duty, vt[r].amp);
         push_period(vt[r].hi_n, vt[r].lo_n, vt[r].amp_exp, vt[r].ps);
         push_period(vt[r].hi_n, vt[r].lo_n, vt[r].amp_exp, vt[r].ps);
         for (int k = 0; k < 2 * (vt[r].hi_n + vt[r].lo_n); k++)
            check_sample($sformatf("row%0d s%0d", r, k));
      end

      // Mid-period duty change waits for the wrap; a second offer while
      // the slot is full is refused.
      start_cfg(16'h1000, 8'h80, 8'd40);
      push_period(8, 8, 40, 1'b1);
      for (int k = 0; k < 5; k++) check_sample($sformatf("mid s%0d", k));
      cfg_valid = 1'b1;
      cfg_ftw   = 16'h1000;
      cfg_duty  = 8'h40;
      cfg_amp   = 8'd40;
      check_sample("mid s5");
      check("mid ready after offer", int'(cfg_ready), 0);
      cfg_duty = 8'hC0;
      for (int k = 6; k < 15; k++) check_sample($sformatf("mid s%0d", k));
      check("mid ready before wrap", int'(cfg_ready), 0);
      check_sample("mid s15");
      check("mid ready after wrap", int'(cfg_ready), 1);
      cfg_valid = 1'b0;
      push_period(4, 12, 40, 1'b1);
      push_period(4, 12, 40, 1'b1);
      for (int k = 16; k < 48; k++) check_sample($sformatf("mid s%0d", k));

      // en dropped mid-period for 3 cycles, then phase restarts from zero.
      start_cfg(16'h1000, 8'h80, 8'd40);
      push_period(6, 0, 40, 1'b1);
      for (int k = 0; k < 6; k++) check_sample($sformatf("pause s%0d", k));
      en = 1'b0;
      push_period(1, 0, 40, 1'b0);
      check_sample("pause s6");
      tick;
      check("pause idle1 wave",   int'(wave_out),     0);
      check("pause idle1 level",  int'(level),        0);
      check("pause idle1 pstart", int'(period_start), 0);
      tick;
      check("pause idle2 wave", int'(wave_out), 0);
      en = 1'b1;
      tick;
      check("pause reentry wave", int'(wave_out), 0);
      push_period(8, 8, 40, 1'b1);
      for (int k = 0; k < 16; k++) check_sample($sformatf("resume s%0d", k));

      // Reset while the pending slot is full discards that config.
      start_cfg(16'h1000, 8'h80, 8'd40);
      push_period(5, 0, 40, 1'b1);
      for (int k = 0; k < 5; k++) check_sample($sformatf("rstp s%0d", k));
      cfg_valid = 1'b1;
      cfg_ftw   = 16'h2000;
      cfg_duty  = 8'h40;
      cfg_amp   = 8'd16;
      tick;
      cfg_valid = 1'b0;
      check("rstp ready pending", int'(cfg_ready), 0);
      rst = 1'b1;
      tick;
      check("rstp wave",   int'(wave_out),     0);
      check("rstp level",  int'(level),        0);
      check("rstp pstart", int'(period_start), 0);
      check("rstp ready",  int'(cfg_ready),    1);
      rst = 1'b0;
      tick;
      check("rstp idle wave", int'(wave_out), 0);
      push_period(20, 0, 40, 1'b0);
      for (int k = 0; k < 20; k++) check_sample($sformatf("rstp post s%0d", k));

`ifdef REC_GEN_SYNC_EN
      // Sync pulse while phase is 0x5000 restarts the period.
      start_cfg(16'h1000, 8'h80, 8'd40);
      push_period(5, 0, 40, 1'b1);
      for (int k = 0; k < 5; k++) check_sample($sformatf("sync s%0d", k));
      sync = 1'b1;
      push_period(1, 0, 40, 1'b0);
      check_sample("sync s5");
      sync = 1'b0;
      push_period(8, 8, 40, 1'b1);
      for (int k = 0; k < 16; k++) check_sample($sformatf("sync post s%0d", k));
`endif

      if (sb.size() != 0) begin
         n_chk++;
         $display("FAIL scoreboard leftover: got %0d entries, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
